// File: rtl/ws2812_rx_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ws2812_rx_decoder: WS2812 single-wire receiver. Recovers bits from the      |
// | high-pulse width, assembles GRB pixels and detects the latch gap.           |
// | Optional macro WS2812_FWD_EN adds chain forwarding on dout.                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ws2812_rx_decoder #(
  parameter int NUM_LEDS  = 16,
  parameter int T_MIN     = 12,
  parameter int T_THRESH  = 75,
  parameter int T_MAXHIGH = 200,
  parameter int T_RESET   = 6250,
  parameter int IDX_W     = $clog2(NUM_LEDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [23:0]      pix_data,
  output logic [IDX_W-1:0] pix_idx,
  output logic             pix_valid,
  output logic             frame_done,
  output logic [IDX_W:0]   pix_count,
  output logic             err,
  output logic             dout
);

  localparam int CNT_W = $clog2(T_RESET + 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(T_RESET);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] MIN_W     = CNT_W'(T_MIN);
  localparam logic [CNT_W-1:0] THRESH_W  = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] MAXHIGH_W = CNT_W'(T_MAXHIGH);
  localparam logic [IDX_W:0]   PX_LIMIT  = (IDX_W + 1)'(NUM_LEDS);

  typedef enum logic [2:0] {
    SYNC = 3'd0,
    IDLE = 3'd1,
    HIGH = 3'd2,
    LOW  = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              din_meta_q, din_meta_d;
  logic              din_sync_q, din_sync_d;
  logic              din_prev_q, din_prev_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]  low_cnt_q, low_cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [IDX_W:0]    px_cnt_q, px_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [23:0]       pix_data_q, pix_data_d;
  logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;
  logic [IDX_W:0]    pix_count_q, pix_count_d;
  logic              pix_valid_q, pix_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
`ifdef WS2812_FWD_EN
  logic              fwd_active_q, fwd_active_d;
  logic              dout_q, dout_d;
`endif

  logic        rise, fall, gap, bit_val;
  logic [23:0] shifted;

  assign rise    = din_sync_q & ~din_prev_q;
  assign fall    = ~din_sync_q & din_prev_q;
  // gap is true on the T_RESET-th consecutive low cycle
  assign gap     = ~din_sync_q && (low_cnt_q >= GAP_LAST);
  assign bit_val = (high_cnt_q >= THRESH_W);
  assign shifted = {shift_q[22:0], bit_val};

  always_comb begin
    din_meta_d   = din;
    din_sync_d   = din_meta_q;
    din_prev_d   = din_sync_q;
    state_d      = state_q;
    high_cnt_d   = high_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    px_cnt_d     = px_cnt_q;
    shift_d      = shift_q;
    pix_data_d   = pix_data_q;
    pix_idx_d    = pix_idx_q;
    pix_count_d  = pix_count_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
`ifdef WS2812_FWD_EN
    fwd_active_d = fwd_active_q;
`endif
    if (din_sync_q)                low_cnt_d = '0;
    else if (low_cnt_q == CNT_SAT) low_cnt_d = low_cnt_q;
    else                           low_cnt_d = low_cnt_q + 1'b1;

    case (state_q)
      SYNC: if (gap) state_d = IDLE;
      IDLE: begin
        if (rise) begin
          high_cnt_d = CNT_W'(1);  // the rising-edge cycle is the first high cycle
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          if (high_cnt_q < MIN_W) begin
            err_d   = 1'b1;
            state_d = DROP;
          end else begin
            shift_d = shifted;
            state_d = LOW;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              px_cnt_d  = (px_cnt_q == '1) ? px_cnt_q : px_cnt_q + 1'b1;
              if (px_cnt_q < PX_LIMIT) begin
                pix_valid_d = 1'b1;
                pix_data_d  = shifted;
                pix_idx_d   = px_cnt_q[IDX_W-1:0];
              end
`ifdef WS2812_FWD_EN
              if (px_cnt_q == '0) fwd_active_d = 1'b1;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end else begin
          high_cnt_d = (high_cnt_q == CNT_SAT) ? high_cnt_q : high_cnt_q + 1'b1;
          if (high_cnt_q >= MAXHIGH_W) begin
            err_d   = 1'b1;
            state_d = DROP;
          end
        end
      end
      LOW: begin
        if (rise) begin
          high_cnt_d = CNT_W'(1);
          state_d    = HIGH;
        end else if (gap) begin
          frame_done_d = 1'b1;
          pix_count_d  = px_cnt_q;
          err_d        = (bit_cnt_q != 5'd0);
          px_cnt_d     = '0;
          bit_cnt_d    = '0;
          state_d      = IDLE;
`ifdef WS2812_FWD_EN
          fwd_active_d = 1'b0;
`endif
        end
      end
      DROP: begin
`ifdef WS2812_FWD_EN
        fwd_active_d = 1'b0;
`endif
        if (gap) begin
          px_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
`ifdef WS2812_FWD_EN
    dout_d = din_sync_q & fwd_active_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SYNC;
      din_meta_q   <= 1'b0;
      din_sync_q   <= 1'b0;
      din_prev_q   <= 1'b0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      px_cnt_q     <= '0;
      shift_q      <= '0;
      pix_data_q   <= '0;
      pix_idx_q    <= '0;
      pix_count_q  <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef WS2812_FWD_EN
      fwd_active_q <= 1'b0;
      dout_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      din_meta_q   <= din_meta_d;
      din_sync_q   <= din_sync_d;
      din_prev_q   <= din_prev_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      px_cnt_q     <= px_cnt_d;
      shift_q      <= shift_d;
      pix_data_q   <= pix_data_d;
      pix_idx_q    <= pix_idx_d;
      pix_count_q  <= pix_count_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
`ifdef WS2812_FWD_EN
      fwd_active_q <= fwd_active_d;
      dout_q       <= dout_d;
`endif
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_idx    = pix_idx_q;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign pix_count  = pix_count_q;
  assign err        = err_q;
`ifdef WS2812_FWD_EN
  assign dout       = dout_q;
`else
  assign dout       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ws2812_rx_decoder.sv
`default_nettype none
// Directed testbench for ws2812_rx_decoder at default parameters.
module tb_ws2812_rx_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [23:0] pix_data;
  logic [3:0]  pix_idx;
  logic        pix_valid;
  logic        frame_done;
  logic [4:0]  pix_count;
  logic        err;
  logic        dout;

  ws2812_rx_decoder dut (
    .clk(clk), .rst_n(rst_n), .din(din), .pix_data(pix_data), .pix_idx(pix_idx),
    .pix_valid(pix_valid), .frame_done(frame_done), .pix_count(pix_count),
    .err(err), .dout(dout)
  );

  always #4 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] dh = 3'b000;
  always @(posedge clk) dh <= {dh[1:0], din};

  // Event recorder; comparisons live in the test tasks.
  logic [23:0] vdata [0:31];
  logic [3:0]  vidx  [0:31];
  int nv = 0, nfd = 0, nerr = 0, nerr_fd = 0, err_cyc = 0;
  logic [4:0] last_cnt = '0;
  int phase = 0, p0_hi = 0, fwd_mis = 0, fwd_hi = 0, dout_hi_any = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid) begin
        if (nv < 32) begin
          vdata[nv] = pix_data;
          vidx[nv]  = pix_idx;
        end
        nv++;
      end
      if (frame_done) begin
        nfd++;
        last_cnt = pix_count;
        if (err) nerr_fd++;
      end
      if (err) begin
        nerr++;
        err_cyc = cyc;
      end
      if (dout) dout_hi_any++;
      if (phase == 1 && dout) p0_hi++;
      if (phase == 2 && dout !== dh[2]) fwd_mis++;
      if (phase == 2 && dout) fwd_hi++;
    end
  end

  task automatic clear_mon();
    nv = 0; nfd = 0; nerr = 0; nerr_fd = 0;
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_px(input logic [23:0] p, input bit slow);
    for (int i = 23; i >= 0; i--) begin
      if (slow) pulse(p[i] ? 100 : 50, p[i] ? 56 : 106);
      else      pulse(p[i] ? 80 : 20, 6);
    end
  endtask

  task automatic gap();
    din = 1'b0;
    repeat (6300) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    if (pix_data !== 24'h0) begin errors++; $display("FAIL rst_pix_data: got %h want 000000", pix_data); end
    checks++;
    if (pix_idx !== 4'h0) begin errors++; $display("FAIL rst_pix_idx: got %0d want 0", pix_idx); end
    checks++;
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_pix_valid: got %b want 0", pix_valid); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    checks++;
    if (pix_count !== 5'd0) begin errors++; $display("FAIL rst_pix_count: got %0d want 0", pix_count); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++;
    if (dout !== 1'b0) begin errors++; $display("FAIL rst_dout: got %b want 0", dout); end
    checks++;
    rst_n = 1'b1;
    clear_mon();
    // bits before the first latch gap must be ignored
    send_px(24'hFFFFFF, 1'b0);
    gap();
    if (nv !== 0) begin errors++; $display("FAIL presync_valid: got %0d want 0", nv); end
    checks++;
    if (nfd !== 0) begin errors++; $display("FAIL presync_frame_done: got %0d want 0", nfd); end
    checks++;
    if (nerr !== 0) begin errors++; $display("FAIL presync_err: got %0d want 0", nerr); end
    checks++;
  endtask

  task automatic test_single_pixel();
    clear_mon();
    send_px(24'hFF0055, 1'b1);
    gap();
    if (nv !== 1) begin errors++; $display("FAIL single_valid_count: got %0d want 1", nv); end
    checks++;
    if (vdata[0] !== 24'hFF0055) begin errors++; $display("FAIL single_data: got %h want ff0055", vdata[0]); end
    checks++;
    if (vidx[0] !== 4'd0) begin errors++; $display("FAIL single_idx: got %0d want 0", vidx[0]); end
    checks++;
    if (nfd !== 1) begin errors++; $display("FAIL single_frame_done: got %0d want 1", nfd); end
    checks++;
    if (last_cnt !== 5'd1) begin errors++; $display("FAIL single_pix_count: got %0d want 1", last_cnt); end
    checks++;
    if (nerr !== 0) begin errors++; $display("FAIL single_err: got %0d want 0", nerr); end
    checks++;
    if (pix_data !== 24'hFF0055) begin errors++; $display("FAIL single_hold: got %h want ff0055", pix_data); end
    checks++;
  endtask

  task automatic test_thresholds();
    clear_mon();
    pulse(12, 6);   // shortest legal pulse -> 0
    pulse(74, 6);   // just below threshold -> 0
    pulse(75, 6);   // at threshold -> 1
    pulse(200, 6);  // longest legal pulse -> 1
    for (int i = 19; i >= 0; i--) begin
      logic [19:0] tail;
      tail = 20'hABCDE;
      pulse(tail[i] ? 80 : 20, 6);
    end
    gap();
    if (nv !== 1 || vdata[0] !== 24'h3ABCDE) begin
      errors++; $display("FAIL thresh_data: got n=%0d data=%h want n=1 data=3abcde", nv, vdata[0]);
    end
    checks++;
    if (nerr !== 0) begin errors++; $display("FAIL thresh_err: got %0d want 0", nerr); end
    checks++;
  endtask

  task automatic test_overflow_frame();
    clear_mon();
    for (int p = 0; p < 18; p++) send_px(24'h010203 + 24'(p), 1'b0);
    gap();
    if (nv !== 16) begin errors++; $display("FAIL ovf_valid_count: got %0d want 16", nv); end
    checks++;
    for (int p = 0; p < 16; p++) begin
      if (vdata[p] !== 24'h010203 + 24'(p) || vidx[p] !== 4'(p)) begin
        errors++;
        $display("FAIL ovf_pixel%0d: got data=%h idx=%0d want data=%h idx=%0d",
                 p, vdata[p], vidx[p], 24'h010203 + 24'(p), p);
      end
      checks++;
    end
    if (nfd !== 1) begin errors++; $display("FAIL ovf_frame_done: got %0d want 1", nfd); end
    checks++;
    if (last_cnt !== 5'd18) begin errors++; $display("FAIL ovf_pix_count: got %0d want 18", last_cnt); end
    checks++;
    if (nerr !== 0) begin errors++; $display("FAIL ovf_err: got %0d want 0", nerr); end
    checks++;
  endtask

  task automatic test_glitch();
    logic [23:0] p2;
    clear_mon();
    send_px(24'h111111, 1'b0);
    send_px(24'h222222, 1'b0);
    p2 = 24'h333333;
    for (int i = 23; i >= 19; i--) pulse(p2[i] ? 80 : 20, 6);
    pulse(8, 6);
    for (int i = 18; i >= 0; i--) pulse(p2[i] ? 80 : 20, 6);
    send_px(24'h444444, 1'b0);
    gap();
    if (nv !== 2) begin errors++; $display("FAIL glitch_valid_count: got %0d want 2", nv); end
    checks++;
    if (nerr !== 1) begin errors++; $display("FAIL glitch_err_count: got %0d want 1", nerr); end
    checks++;
    if (nfd !== 0) begin errors++; $display("FAIL glitch_frame_done: got %0d want 0", nfd); end
    checks++;
    clear_mon();
    send_px(24'h00C0FF, 1'b0);
    gap();
    if (nv !== 1 || vdata[0] !== 24'h00C0FF || vidx[0] !== 4'd0) begin
      errors++; $display("FAIL glitch_recover: got n=%0d data=%h idx=%0d want n=1 data=00c0ff idx=0",
                         nv, vdata[0], vidx[0]);
    end
    checks++;
    if (nfd !== 1 || last_cnt !== 5'd1) begin
      errors++; $display("FAIL glitch_recover_frame: got fd=%0d cnt=%0d want fd=1 cnt=1", nfd, last_cnt);
    end
    checks++;
  endtask

  task automatic test_stuck_high();
    int c0;
    clear_mon();
    c0 = cyc;
    din = 1'b1;
    repeat (300) @(negedge clk);
    din = 1'b0;
    repeat (6300) @(negedge clk);
    if (nerr !== 1) begin errors++; $display("FAIL stuck_err_count: got %0d want 1", nerr); end
    checks++;
    // 2 sync stages + edge register + 201st high cycle + output register
    if (err_cyc - c0 !== 203) begin errors++; $display("FAIL stuck_err_time: got %0d want 203", err_cyc - c0); end
    checks++;
    if (nfd !== 0 || nv !== 0) begin
      errors++; $display("FAIL stuck_drop: got fd=%0d valid=%0d want 0 0", nfd, nv);
    end
    checks++;
  endtask

  task automatic test_partial();
    clear_mon();
    for (int i = 0; i < 10; i++) pulse((i % 2) ? 80 : 20, 6);
    gap();
    if (nerr !== 1 || nerr_fd !== 1) begin
      errors++; $display("FAIL partial_err: got err=%0d with_fd=%0d want 1 1", nerr, nerr_fd);
    end
    checks++;
    if (nfd !== 1) begin errors++; $display("FAIL partial_frame_done: got %0d want 1", nfd); end
    checks++;
    if (last_cnt !== 5'd0) begin errors++; $display("FAIL partial_pix_count: got %0d want 0", last_cnt); end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL partial_valid: got %0d want 0", nv); end
    checks++;
  endtask

`ifdef WS2812_FWD_EN
  task automatic test_forward();
    clear_mon();
    p0_hi = 0; fwd_mis = 0; fwd_hi = 0;
    phase = 1;
    send_px(24'hA5A5A5, 1'b0);
    phase = 2;
    send_px(24'h5A5A5A, 1'b0);
    send_px(24'hF0F00F, 1'b0);
    phase = 0;
    gap();
    phase = 1;
    send_px(24'hFFFFFF, 1'b0);
    phase = 0;
    gap();
    if (p0_hi !== 0) begin errors++; $display("FAIL fwd_pixel0_low: got %0d high cycles want 0", p0_hi); end
    checks++;
    if (fwd_mis !== 0) begin errors++; $display("FAIL fwd_follow: got %0d differing cycles want 0", fwd_mis); end
    checks++;
    if (fwd_hi == 0) begin errors++; $display("FAIL fwd_active: got %0d high cycles want >0", fwd_hi); end
    checks++;
    if (nv !== 4) begin errors++; $display("FAIL fwd_decode: got %0d pixels want 4", nv); end
    checks++;
  endtask
`else
  task automatic test_dout_tied();
    if (dout_hi_any !== 0) begin errors++; $display("FAIL dout_tied: got %0d high cycles want 0", dout_hi_any); end
    checks++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single_pixel();
    test_thresholds();
    test_overflow_frame();
    test_glitch();
    test_stuck_high();
    test_partial();
`ifdef WS2812_FWD_EN
    test_forward();
`else
    test_dout_tied();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
